// File: rtl/podule_bus.sv
// Expansion-bus controller: decodes host accesses to podule slots, inserts IOC-speed wait
// states, waits for slot ready with a timeout, and merges slot interrupts for the IOC.
//
// state     | meaning
// S_IDLE    | no access; accept a new strobe
// S_WAIT    | slot strobed, counting IOC-speed wait states
// S_READY   | slot strobed, sampling pod_rdy, timeout counting
// S_ACK     | one-cycle host acknowledge, slot released
// S_RELEASE | waiting for the host to drop its strobe
module podule_bus #(
  parameter int NUM_SLOTS = 4,
  parameter int WAIT_SLOW = 6,
  parameter int WAIT_MED  = 4,
  parameter int WAIT_FAST = 2,
  parameter int WAIT_SYNC = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clkcpu,
  input  logic                   rst_i,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  input  logic                   wb_we,
  input  logic [13:0]            wb_adr,
  input  logic [1:0]             wb_speed,
  input  logic [15:0]            wb_dat_i,
  output logic [15:0]            wb_dat_o,
  output logic                   wb_ack,
  output logic [NUM_SLOTS-1:0]   pod_sel,
  output logic                   pod_we,
  output logic [11:0]            pod_adr,
  output logic [15:0]            pod_wdat,
  input  logic [16*NUM_SLOTS-1:0] pod_rdat,
  input  logic [NUM_SLOTS-1:0]   pod_rdy,
  input  logic [NUM_SLOTS-1:0]   present,
  input  logic [NUM_SLOTS-1:0]   pod_irq,
  input  logic [NUM_SLOTS-1:0]   pod_firq,
  output logic                   irq_n,
  output logic                   firq_n,
  output logic [NUM_SLOTS-1:0]   irq_pend,
  output logic                   timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_READY, S_ACK, S_RELEASE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_slot;
  logic [7:0]           r_cnt;
  logic [7:0]           r_tmo;
  logic [15:0]          r_dat;
  logic                 r_we;
  logic [11:0]          r_adr;
  logic [15:0]          r_wdat;
  logic                 r_timeout;
  logic [NUM_SLOTS-1:0] r_irq_pend;
  logic                 r_irq_n;
  logic                 r_firq_n;

  // Zero-extended to four slots so unimplemented slot numbers decode as absent.
  logic [3:0]  w_present4;
  logic [3:0]  w_rdy4;
  logic [63:0] w_rdat64;
  logic        w_req;
  logic [1:0]  w_slot;
  logic        w_hit;
  logic        w_rdy;
  logic        w_tmo_last;
  logic [7:0]  w_wait_init;
  logic [15:0] w_rdat_sel;

  assign w_present4 = 4'(present);
  assign w_rdy4     = 4'(pod_rdy);
  assign w_rdat64   = 64'(pod_rdat);
  assign w_req      = wb_cyc & wb_stb;
  assign w_slot     = wb_adr[13:12];
  assign w_hit      = w_present4[w_slot];
  assign w_rdy      = w_rdy4[r_slot];
  assign w_tmo_last = (r_tmo == 8'(TIMEOUT - 1));
  assign w_rdat_sel = w_rdat64[{r_slot, 4'b0000} +: 16];

  always_comb begin
    case (wb_speed)
      2'd0:    w_wait_init = 8'(WAIT_SLOW);
      2'd1:    w_wait_init = 8'(WAIT_MED);
      2'd2:    w_wait_init = 8'(WAIT_FAST);
      default: w_wait_init = 8'(WAIT_SYNC);
    endcase
  end

  always_ff @(posedge clkcpu) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_req) w_next = w_hit ? S_WAIT : S_ACK;
      S_WAIT: begin
        if (!wb_cyc)            w_next = S_IDLE;
        else if (r_cnt == 8'd1) w_next = S_READY;
      end
      S_READY: begin
        if (!wb_cyc)                 w_next = S_IDLE;
        else if (w_rdy || w_tmo_last) w_next = S_ACK;
      end
      S_ACK:     w_next = S_RELEASE;
      S_RELEASE: if (!wb_stb || !wb_cyc) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    wb_ack  = (r_state == S_ACK);
    pod_sel = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pod_sel[i] = ((r_state == S_WAIT) || (r_state == S_READY)) && (r_slot == 2'(i));
    end
  end

  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      r_slot    <= 2'd0;
      r_cnt     <= 8'd0;
      r_tmo     <= 8'd0;
      r_dat     <= 16'hFFFF;
      r_we      <= 1'b0;
      r_adr     <= 12'd0;
      r_wdat    <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_slot <= w_slot;
            r_adr  <= wb_adr[11:0];
            r_wdat <= wb_dat_i;
            r_cnt  <= w_wait_init;
            if (w_hit) r_we  <= wb_we;
            else       r_dat <= 16'hFFFF;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          r_tmo <= 8'd0;
        end
        S_READY: begin
          if (wb_cyc) begin
            if (w_rdy) begin
              r_dat <= r_we ? 16'hFFFF : w_rdat_sel;
            end else if (w_tmo_last) begin
              r_timeout <= 1'b1;
              r_dat     <= 16'hFFFF;
            end else begin
              r_tmo <= r_tmo + 8'd1;
            end
          end
        end
        default: ;
      endcase
      // Write enable only lives for the duration of an access.
      if (w_next == S_IDLE) r_we <= 1'b0;
    end
  end

  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      r_irq_pend <= '0;
      r_irq_n    <= 1'b1;
      r_firq_n   <= 1'b1;
    end else begin
      r_irq_pend <= pod_irq & present;
      r_irq_n    <= ~|(pod_irq & present);
      r_firq_n   <= ~|(pod_firq & present);
    end
  end

  assign wb_dat_o  = r_dat;
  assign pod_we    = r_we;
  assign pod_adr   = r_adr;
  assign pod_wdat  = r_wdat;
  assign timeout_o = r_timeout;
  assign irq_pend  = r_irq_pend;
  assign irq_n     = r_irq_n;
  assign firq_n    = r_firq_n;

endmodule

// File: tb/tb_podule_bus.sv
// Directed bench for podule_bus: expected ack data/latency/timeout are pushed to a scoreboard
// when an access is driven and popped when the controller acknowledges.
module tb_podule_bus;
  localparam int NS  = 4;
  localparam int TMO = 64;

  logic          clkcpu = 1'b0;
  logic          rst_i;
  logic          wb_cyc, wb_stb, wb_we;
  logic [13:0]   wb_adr;
  logic [1:0]    wb_speed;
  logic [15:0]   wb_dat_i;
  logic [15:0]   wb_dat_o;
  logic          wb_ack;
  logic [NS-1:0] pod_sel;
  logic          pod_we;
  logic [11:0]   pod_adr;
  logic [15:0]   pod_wdat;
  logic [63:0]   pod_rdat;
  logic [NS-1:0] pod_rdy, present, pod_irq, pod_firq, irq_pend;
  logic          irq_n, firq_n, timeout_o;

  always #5 clkcpu = ~clkcpu;

  podule_bus #(.NUM_SLOTS(NS), .WAIT_SLOW(6), .WAIT_MED(4), .WAIT_FAST(2), .WAIT_SYNC(1),
               .TIMEOUT(TMO)) dut (
    .clkcpu(clkcpu), .rst_i(rst_i), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_speed(wb_speed), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack(wb_ack), .pod_sel(pod_sel), .pod_we(pod_we), .pod_adr(pod_adr),
    .pod_wdat(pod_wdat), .pod_rdat(pod_rdat), .pod_rdy(pod_rdy), .present(present),
    .pod_irq(pod_irq), .pod_firq(pod_firq), .irq_n(irq_n), .firq_n(firq_n),
    .irq_pend(irq_pend), .timeout_o(timeout_o)
  );

  typedef struct {
    logic [15:0] data;
    int          lat;
    logic        tmo;
    int          sel;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic int wait_of(input logic [1:0] spd);
    case (spd)
      2'd0:    return 6;
      2'd1:    return 4;
      2'd2:    return 2;
      default: return 1;
    endcase
  endfunction

  task automatic access(input logic [13:0] adr, input logic we, input logic [15:0] wdat,
                        input logic [1:0] spd, input int hold, input string tag);
    exp_t        e;
    exp_t        got_e;
    int          w;
    int          n;
    int          sel;
    int          bad;
    int          extra;
    logic        got;
    logic [1:0]  s;
    logic [3:0]  onehot;
    w      = wait_of(spd);
    s      = adr[13:12];
    onehot = 4'b0001 << s;
    if (!present[s])      e = '{16'hFFFF, 1, 1'b0, 0};
    else if (pod_rdy[s])  e = '{(we ? 16'hFFFF : pod_rdat[16*s +: 16]), w + 2, 1'b0, w + 1};
    else                  e = '{16'hFFFF, 1 + w + TMO, 1'b1, w + TMO};
    sb.push_back(e);
    @(negedge clkcpu);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_speed = spd; wb_dat_i = wdat;
    n = 0; sel = 0; bad = 0; extra = 0; got = 1'b0;
    while (!got && n < 300) begin
      @(posedge clkcpu); #1;
      n++;
      if (pod_sel != '0) begin
        sel++;
        if (pod_sel !== onehot || pod_we !== we || pod_adr !== adr[11:0] ||
            (we && pod_wdat !== wdat)) bad++;
      end
      if (wb_ack === 1'b1) begin
        got   = 1'b1;
        got_e = sb.pop_front();
        chk({tag, " latency"}, 32'(n), 32'(got_e.lat));
        chk({tag, " data"}, 32'(wb_dat_o), 32'(got_e.data));
        chk({tag, " timeout_o"}, 32'(timeout_o), 32'(got_e.tmo));
        chk({tag, " sel_cycles"}, 32'(sel), 32'(got_e.sel));
        chk({tag, " sel_at_ack"}, 32'(pod_sel), 32'd0);
      end
    end
    chk({tag, " ack_seen"}, 32'(got), 32'd1);
    if (!got) void'(sb.pop_front());
    for (int i = 0; i < hold + 1; i++) begin
      @(posedge clkcpu); #1;
      if (wb_ack === 1'b1) extra++;
    end
    chk({tag, " extra_acks"}, 32'(extra), 32'd0);
    chk({tag, " slot_bus"}, 32'(bad), 32'd0);
    @(negedge clkcpu);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clkcpu); #1;
  endtask

  initial begin : stim
    int acks;
    rst_i = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_speed = '0;
    wb_dat_i = '0; pod_rdy = 4'b1111; present = 4'b0001; pod_irq = '0; pod_firq = '0;
    pod_rdat = {16'h4444, 16'h3333, 16'hA5C3, 16'h1234};
    repeat (3) @(posedge clkcpu);
    #1;
    chk("rst wb_ack", 32'(wb_ack), 32'd0);
    chk("rst pod_sel", 32'(pod_sel), 32'd0);
    chk("rst wb_dat_o", 32'(wb_dat_o), 32'hFFFF);
    chk("rst pod_we", 32'(pod_we), 32'd0);
    chk("rst pod_adr", 32'(pod_adr), 32'd0);
    chk("rst pod_wdat", 32'(pod_wdat), 32'd0);
    chk("rst irq_n", 32'(irq_n), 32'd1);
    chk("rst firq_n", 32'(firq_n), 32'd1);
    chk("rst irq_pend", 32'(irq_pend), 32'd0);
    chk("rst timeout_o", 32'(timeout_o), 32'd0);
    @(negedge clkcpu);
    rst_i = 1'b0;

    access(14'h0040, 1'b0, 16'h0000, 2'd2, 0, "t1 read slot0");
    access(14'h0123, 1'b1, 16'hBEEF, 2'd0, 5, "t2 write slot0");
    access(14'h2010, 1'b0, 16'h0000, 2'd2, 0, "t3 absent slot2");
    present = 4'b0011;
    access(14'h1abc, 1'b0, 16'h0000, 2'd1, 2, "t1b read slot1");
    present = 4'b0001;
    pod_rdy = 4'b0000;
    access(14'h0004, 1'b0, 16'h0000, 2'd3, 0, "t4 timeout");
    pod_rdy = 4'b1111;
    access(14'h0008, 1'b0, 16'h0000, 2'd3, 0, "t4b after timeout");

    // Host abandons in the wait phase.
    @(negedge clkcpu);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 14'h0010; wb_speed = 2'd0;
    repeat (3) @(posedge clkcpu);
    #1;
    chk("abandon sel_before", 32'(pod_sel), 32'h1);
    @(negedge clkcpu);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clkcpu); #1;
    chk("abandon sel_after", 32'(pod_sel), 32'd0);
    acks = 0;
    repeat (10) begin
      @(posedge clkcpu); #1;
      if (wb_ack === 1'b1) acks++;
    end
    chk("abandon acks", 32'(acks), 32'd0);

    // Interrupt merging, one registered cycle of latency.
    @(negedge clkcpu);
    pod_irq = 4'b0101; pod_firq = 4'b0010;
    #1;
    chk("irq latency", 32'(irq_n), 32'd1);
    @(posedge clkcpu); #1;
    chk("irq_n asserted", 32'(irq_n), 32'd0);
    chk("irq_pend", 32'(irq_pend), 32'h1);
    chk("firq absent slot", 32'(firq_n), 32'd1);
    @(negedge clkcpu);
    pod_irq = 4'b0100; pod_firq = 4'b0001;
    @(posedge clkcpu); #1;
    chk("irq_n absent only", 32'(irq_n), 32'd1);
    chk("irq_pend cleared", 32'(irq_pend), 32'd0);
    chk("firq_n asserted", 32'(firq_n), 32'd0);
    @(negedge clkcpu);
    pod_irq = '0; pod_firq = '0;

    // Reset while the slot is stalled in READY.
    pod_rdy = 4'b0000;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 14'h0123; wb_speed = 2'd0;
    wb_dat_i = 16'h5A5A;
    repeat (10) @(posedge clkcpu);
    #1;
    chk("t6 in ready sel", 32'(pod_sel), 32'h1);
    chk("t6 in ready adr", 32'(pod_adr), 32'h123);
    @(negedge clkcpu);
    rst_i = 1'b1;
    @(posedge clkcpu); #1;
    chk("t6 sel", 32'(pod_sel), 32'd0);
    chk("t6 ack", 32'(wb_ack), 32'd0);
    chk("t6 dat", 32'(wb_dat_o), 32'hFFFF);
    chk("t6 adr", 32'(pod_adr), 32'd0);
    chk("t6 we", 32'(pod_we), 32'd0);
    chk("t6 wdat", 32'(pod_wdat), 32'd0);
    @(negedge clkcpu);
    rst_i = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    acks = 0;
    repeat (5) begin
      @(posedge clkcpu); #1;
      if (wb_ack === 1'b1) acks++;
    end
    chk("t6 no ack", 32'(acks), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
